// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer: power-up delay, fixed 11-entry init table,
// then single runtime register writes, all through an action/busy I2C write engine.
module wm8731_cfg_seq #(
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         STARTUP_CYCLES = 500000,
  parameter int         GAP_CYCLES     = 1000,
  parameter int         ACT_TO         = 8,
  parameter int         BUSY_TO        = 20000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       restart,
  input  logic       usr_req,
  input  logic [6:0] usr_reg_addr,
  input  logic [8:0] usr_reg_data,
  output logic       usr_ack,
  output logic       action,
  input  logic       busy,
  output logic [6:0] dev_addr,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       init_done,
  output logic       err,
  output logic [3:0] err_idx
);

  localparam int M1      = (STARTUP_CYCLES > BUSY_TO) ? STARTUP_CYCLES : BUSY_TO;
  localparam int M2      = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
  localparam int CNT_MAX = (M2 > ACT_TO) ? M2 : ACT_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PWR_LAST  = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] ACT_LAST  = CW'(ACT_TO - 1);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TO - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [3:0]    LAST_IDX  = 4'd10;
  localparam logic [3:0]    RT_IDX    = 4'hF;

  typedef enum logic [2:0] {
    S_PWR, S_LOAD, S_ISSUE, S_BUSY, S_GAP, S_IDLE, S_ERR
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_wr_t;

  function automatic cfg_wr_t init_entry(input logic [3:0] i);
    cfg_wr_t e;
    case (i)
      4'd0:    e = {7'h0F, 9'h000};
      4'd1:    e = {7'h06, 9'h010};
      4'd2:    e = {7'h00, 9'h017};
      4'd3:    e = {7'h01, 9'h017};
      4'd4:    e = {7'h02, 9'h079};
      4'd5:    e = {7'h03, 9'h079};
      4'd6:    e = {7'h04, 9'h012};
      4'd7:    e = {7'h05, 9'h000};
      4'd8:    e = {7'h07, 9'h002};
      4'd9:    e = {7'h08, 9'h000};
      default: e = {7'h09, 9'h001};
    endcase
    return e;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          rt_q, rt_d;
  cfg_wr_t       wr_q, wr_d;
  logic          ack_q, ack_d;
  logic [3:0]    err_idx_q, err_idx_d;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_PWR;
      cnt_q     <= '0;
      idx_q     <= '0;
      rt_q      <= 1'b0;
      wr_q      <= '0;
      ack_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rt_q      <= rt_d;
      wr_q      <= wr_d;
      ack_q     <= ack_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rt_d      = rt_q;
    wr_d      = wr_q;
    ack_d     = 1'b0;
    err_idx_d = err_idx_q;
    case (state_q)
      S_PWR:   if (cnt_q == PWR_LAST) state_d = S_LOAD;
      S_LOAD: begin
        wr_d    = init_entry(idx_q);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (busy) begin
          state_d = S_BUSY;
        end else if (cnt_q == ACT_LAST) begin
          state_d   = S_ERR;
          err_idx_d = rt_q ? RT_IDX : idx_q;
        end
      end
      S_BUSY: begin
        if (!busy) begin
          state_d = S_GAP;
          ack_d   = rt_q;
        end else if (cnt_q == BUSY_LAST) begin
          state_d   = S_ERR;
          err_idx_d = rt_q ? RT_IDX : idx_q;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (rt_q) begin
            rt_d    = 1'b0;
            state_d = S_IDLE;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_IDLE: begin
        // restart wins over a simultaneous runtime request
        if (restart) begin
          idx_d   = '0;
          rt_d    = 1'b0;
          state_d = S_LOAD;
        end else if (usr_req) begin
          wr_d    = {usr_reg_addr, usr_reg_data};
          rt_d    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ERR: begin
        if (restart) begin
          idx_d   = '0;
          rt_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_PWR;
    endcase
    // every state timer starts from zero on entry and saturates
    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);
  end

  assign action    = (state_q == S_ISSUE);
  assign init_done = (state_q == S_IDLE);
  assign err       = (state_q == S_ERR);
  assign err_idx   = err_idx_q;
  assign usr_ack   = ack_q;
  assign dev_addr  = DEV_ADDR;
  assign reg_addr  = wr_q.addr;
  assign reg_data  = wr_q.data;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: write-engine model logs every accepted write,
// expected init table held as a vector array, corner cases as directed sequences.
module tb_wm8731_cfg_seq;

  logic       sysclk = 1'b0;
  logic       reset, restart, usr_req, busy;
  logic [6:0] usr_reg_addr, dev_addr, reg_addr;
  logic [8:0] usr_reg_data, reg_data;
  logic       usr_ack, action, init_done, err;
  logic [3:0] err_idx;

  wm8731_cfg_seq #(
    .DEV_ADDR(7'h1A), .STARTUP_CYCLES(100), .GAP_CYCLES(10), .ACT_TO(8), .BUSY_TO(200)
  ) dut (
    .sysclk(sysclk), .reset(reset), .restart(restart), .usr_req(usr_req),
    .usr_reg_addr(usr_reg_addr), .usr_reg_data(usr_reg_data), .usr_ack(usr_ack),
    .action(action), .busy(busy), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .reg_data(reg_data), .init_done(init_done), .err(err), .err_idx(err_idx)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [6:0] a;
    logic [8:0] d;
  } vec_t;
  vec_t tbl[11];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // engine model: busy one cycle after action, high 50 cycles
  logic       eng_drop_en = 1'b0;
  logic [6:0] eng_drop_addr = 7'h00;
  logic       eng_stuck = 1'b0;
  int         eng_cnt;
  logic [6:0] log_a[128];
  logic [8:0] log_d[128];
  logic [6:0] log_dev[128];
  int         log_n = 0;

  initial begin
    busy = 1'b0;
    eng_cnt = 0;
    forever begin
      @(posedge sysclk);
      #1;
      if (busy) begin
        if (!eng_stuck) begin
          eng_cnt = eng_cnt - 1;
          if (eng_cnt == 0) busy = 1'b0;
        end
      end else if (action && !(eng_drop_en && reg_addr == eng_drop_addr)) begin
        busy = 1'b1;
        eng_cnt = 50;
        if (log_n < 128) begin
          log_a[log_n]   = reg_addr;
          log_d[log_n]   = reg_data;
          log_dev[log_n] = dev_addr;
          log_n = log_n + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return action;
      1:       return init_done;
      2:       return err;
      default: return usr_ack;
    endcase
  endfunction

  task automatic wait_for(input int w, input int lim, input string nm, output int cyc);
    cyc = 0;
    while (!sig(w) && cyc < lim) begin
      tick();
      cyc++;
    end
    chk(nm, 32'(sig(w)), 32'd1);
  endtask

  task automatic pulse_restart();
    @(negedge sysclk);
    restart = 1'b1;
    @(negedge sysclk);
    restart = 1'b0;
  endtask

  task automatic check_table(input int base, input string tag);
    chk({tag, "_count"}, 32'(log_n - base), 32'd11);
    for (int k = 0; k < 11; k++)
      chk($sformatf("%s_entry%0d", tag, k), 32'({log_a[base+k], log_d[base+k]}),
          32'({tbl[k].a, tbl[k].d}));
    chk({tag, "_dev"}, 32'(log_dev[base]), 32'h1A);
  endtask

  initial begin
    int cyc, base, acks, t_mark, n;
    logic seen_done, early, prev;

    tbl[0]  = '{7'h0F, 9'h000};
    tbl[1]  = '{7'h06, 9'h010};
    tbl[2]  = '{7'h00, 9'h017};
    tbl[3]  = '{7'h01, 9'h017};
    tbl[4]  = '{7'h02, 9'h079};
    tbl[5]  = '{7'h03, 9'h079};
    tbl[6]  = '{7'h04, 9'h012};
    tbl[7]  = '{7'h05, 9'h000};
    tbl[8]  = '{7'h07, 9'h002};
    tbl[9]  = '{7'h08, 9'h000};
    tbl[10] = '{7'h09, 9'h001};

    reset = 1'b0; restart = 1'b0; usr_req = 1'b0;
    usr_reg_addr = '0; usr_reg_data = '0;

    // reset state
    repeat (3) tick();
    chk("rst_action", 32'(action), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    chk("rst_usr_ack", 32'(usr_ack), 32'd0);
    chk("rst_reg", 32'({reg_addr, reg_data}), 32'd0);
    chk("rst_dev_addr", 32'(dev_addr), 32'h1A);

    // power-up: first action 101 cycles after release, full table in order
    base = log_n;
    @(negedge sysclk);
    reset = 1'b1;
    wait_for(0, 300, "pwr_action_seen", cyc);
    chk("pwr_first_action_cycle", 32'(cyc), 32'd101);
    wait_for(1, 3000, "pwr_init_done", cyc);
    check_table(base, "pwr");
    chk("pwr_err", 32'(err), 32'd0);

    // runtime write from IDLE
    usr_reg_addr = 7'h02; usr_reg_data = 9'h06F; usr_req = 1'b1;
    wait_for(0, 20, "rt_action_seen", cyc);
    chk("rt_reg_addr", 32'(reg_addr), 32'h02);
    chk("rt_reg_data", 32'(reg_data), 32'h06F);
    chk("rt_init_done_low", 32'(init_done), 32'd0);
    acks = 0;
    for (n = 0; n < 200; n++) begin
      tick();
      if (usr_ack) begin
        acks++;
        chk("rt_busy_low_at_ack", 32'(busy), 32'd0);
        usr_req = 1'b0;
      end
      if (init_done) break;
    end
    chk("rt_ack_pulses", 32'(acks), 32'd1);
    chk("rt_back_idle", 32'(init_done), 32'd1);
    chk("rt_logged", 32'({log_a[log_n-1], log_d[log_n-1]}), 32'({7'h02, 9'h06F}));

    // runtime request raised during entry 4 is held until the table completes
    base = log_n;
    pulse_restart();
    for (n = 0; n < 2000 && (log_n - base) < 5; n++) tick();
    chk("pend_reached_entry4", 32'(log_n - base), 32'd5);
    usr_reg_addr = 7'h04; usr_reg_data = 9'h055; usr_req = 1'b1;
    seen_done = 1'b0; early = 1'b0; acks = 0;
    for (n = 0; n < 3000; n++) begin
      tick();
      if (init_done) seen_done = 1'b1;
      if (usr_ack) begin
        if (!seen_done) early = 1'b1;
        acks++;
        usr_req = 1'b0;
        break;
      end
    end
    chk("pend_ack_seen", 32'(acks), 32'd1);
    chk("pend_no_early_ack", 32'(early), 32'd0);
    chk("pend_done_before_ack", 32'(seen_done), 32'd1);
    chk("pend_count", 32'(log_n - base), 32'd12);
    chk("pend_last_entry", 32'({log_a[base+10], log_d[base+10]}), 32'({7'h09, 9'h001}));
    chk("pend_rt_entry", 32'({log_a[base+11], log_d[base+11]}), 32'({7'h04, 9'h055}));
    wait_for(1, 50, "pend_idle", cyc);

    // engine never answers entry 3 -> ACT_TO error, then restart without delay
    eng_drop_addr = 7'h01; eng_drop_en = 1'b1;
    base = log_n;
    pulse_restart();
    prev = 1'b0; t_mark = 0;
    for (n = 0; n < 2000; n++) begin
      tick();
      if (action && !prev) t_mark = n;
      prev = action;
      if (err) break;
    end
    chk("act_to_err", 32'(err), 32'd1);
    chk("act_to_err_idx", 32'(err_idx), 32'd3);
    chk("act_to_action_low", 32'(action), 32'd0);
    chk("act_to_cycles", 32'(n - t_mark), 32'd8);
    chk("act_to_logged", 32'(log_n - base), 32'd3);
    repeat (5) tick();
    chk("act_to_err_idx_frozen", 32'(err_idx), 32'd3);
    eng_drop_en = 1'b0;
    base = log_n;
    pulse_restart();
    wait_for(0, 20, "err_restart_action", cyc);
    chk("err_restart_latency", 32'(cyc), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    wait_for(1, 3000, "err_restart_done", cyc);
    check_table(base, "err_restart");

    // busy stuck high on a runtime write -> BUSY_TO error, err_idx F
    eng_stuck = 1'b1;
    usr_reg_addr = 7'h05; usr_reg_data = 9'h008; usr_req = 1'b1;
    prev = 1'b0; t_mark = 0; acks = 0;
    for (n = 0; n < 1000; n++) begin
      tick();
      if (prev && !action) t_mark = n;
      prev = action;
      if (usr_ack) acks++;
      if (err) break;
    end
    chk("busy_to_err", 32'(err), 32'd1);
    chk("busy_to_err_idx", 32'(err_idx), 32'hF);
    chk("busy_to_cycles", 32'(n - t_mark), 32'd200);
    chk("busy_to_no_ack", 32'(acks), 32'd0);
    usr_req = 1'b0;
    eng_stuck = 1'b0;
    repeat (60) tick();

    // async reset during entry 6 busy -> full power-up and whole table again
    base = log_n;
    pulse_restart();
    for (n = 0; n < 2000 && (log_n - base) < 7; n++) tick();
    chk("rst_mid_reached_entry6", 32'(log_n - base), 32'd7);
    repeat (3) tick();
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_action", 32'(action), 32'd0);
    chk("rst_mid_err_idx", 32'(err_idx), 32'd0);
    chk("rst_mid_reg", 32'({reg_addr, reg_data}), 32'd0);
    repeat (3) tick();
    base = log_n;
    @(negedge sysclk);
    reset = 1'b1;
    wait_for(0, 300, "rst_mid_action_seen", cyc);
    chk("rst_mid_first_action_cycle", 32'(cyc), 32'd101);
    wait_for(1, 3000, "rst_mid_done", cyc);
    check_table(base, "rst_mid");
    chk("rst_mid_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
